exu_dp_modport: RTL and testbench



---
 rtl/exu_pkg.sv | 21 ++
 rtl/exu_dp_modport_if.sv | 32 +++
 rtl/exu_alu.sv | 36 +++
 rtl/exu_dp_modport.sv | 54 +++++
 tb/tb_exu_dp_modport.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/exu_pkg.sv
// rtl/exu_pkg.sv - shared EXU constants and ALU opcode encodings
package exu_pkg;

  localparam int XLEN      = 32;
  localparam int GPR_AW    = 5;
  localparam int ALU_OPC_W = 4;

  typedef enum logic [ALU_OPC_W-1:0] {
    ALU_OPCODE_ADD    = 4'd0,
    ALU_OPCODE_SUB    = 4'd1,
    ALU_OPCODE_LESS_S = 4'd2,
    ALU_OPCODE_LESS_U = 4'd3,
    ALU_OPCODE_XOR    = 4'd4,
    ALU_OPCODE_OR     = 4'd5,
    ALU_OPCODE_AND    = 4'd6,
    ALU_OPCODE_SL     = 4'd7,
    ALU_OPCODE_SRL    = 4'd8,
    ALU_OPCODE_SRA    = 4'd9
  } alu_opcode_e;

endpackage

// File: rtl/exu_dp_modport_if.sv
// rtl/exu_dp_modport_if.sv - EXU controller to datapath port bundle
interface exu_dp_modport_if #(
  parameter int XLEN      = exu_pkg::XLEN,
  parameter int GPR_AW    = exu_pkg::GPR_AW,
  parameter int ALU_OPC_W = exu_pkg::ALU_OPC_W
);

  logic [GPR_AW-1:0]    gpr_raddr1;
  logic [XLEN-1:0]      gpr_rdata1;
  logic [GPR_AW-1:0]    gpr_raddr2;
  logic [XLEN-1:0]      gpr_rdata2;
  logic [GPR_AW-1:0]    gpr_waddr;
  logic [XLEN-1:0]      gpr_wdata;
  logic                 gpr_wen;
  logic [ALU_OPC_W-1:0] alu_opcode;
  logic [XLEN-1:0]      alu_src1;
  logic [XLEN-1:0]      alu_src2;
  logic [XLEN-1:0]      alu_dst;

  modport master (
    output gpr_raddr1, gpr_raddr2, gpr_waddr, gpr_wdata, gpr_wen,
    output alu_opcode, alu_src1, alu_src2,
    input  gpr_rdata1, gpr_rdata2, alu_dst
  );

  modport slave (
    input  gpr_raddr1, gpr_raddr2, gpr_waddr, gpr_wdata, gpr_wen,
    input  alu_opcode, alu_src1, alu_src2,
    output gpr_rdata1, gpr_rdata2, alu_dst
  );

endinterface

// File: rtl/exu_alu.sv
// rtl/exu_alu.sv - purely combinational RV32I integer ALU
module exu_alu #(
  parameter int XLEN      = exu_pkg::XLEN,
  parameter int ALU_OPC_W = exu_pkg::ALU_OPC_W
) (
  input  logic [ALU_OPC_W-1:0] opcode,
  input  logic [XLEN-1:0]      src1,
  input  logic [XLEN-1:0]      src2,
  output logic [XLEN-1:0]      dst
);
  import exu_pkg::*;

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = src2[SHW-1:0];

  always_comb begin
    dst = '0;
    // Unassigned encodings fall through to the zero default
    case (alu_opcode_e'(opcode))
      ALU_OPCODE_ADD:    dst = src1 + src2;
      ALU_OPCODE_SUB:    dst = src1 - src2;
      ALU_OPCODE_LESS_S: dst = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      ALU_OPCODE_LESS_U: dst = {{(XLEN-1){1'b0}}, (src1 < src2)};
      ALU_OPCODE_XOR:    dst = src1 ^ src2;
      ALU_OPCODE_OR:     dst = src1 | src2;
      ALU_OPCODE_AND:    dst = src1 & src2;
      ALU_OPCODE_SL:     dst = src1 << shamt;
      ALU_OPCODE_SRL:    dst = src1 >> shamt;
      ALU_OPCODE_SRA:    dst = $unsigned($signed(src1) >>> shamt);
      default:           dst = '0;
    endcase
  end

endmodule

// File: rtl/exu_dp_modport.sv
// rtl/exu_dp_modport.sv - EXU datapath: 2R1W GPR file plus ALU (option EXU_DP_WR_BYPASS_EN)
module exu_dp_modport #(
  parameter int XLEN      = exu_pkg::XLEN,
  parameter int GPR_AW    = exu_pkg::GPR_AW,
  parameter int ALU_OPC_W = exu_pkg::ALU_OPC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  exu_dp_modport_if.slave   bus
);

  localparam int NREG = 2**GPR_AW;

  // x0 has no storage; it is hardwired to zero on the read side
  logic [XLEN-1:0] gpr [1:NREG-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        gpr[i] <= '0;
      end
    end else if (bus.gpr_wen && (bus.gpr_waddr != '0)) begin
      gpr[bus.gpr_waddr] <= bus.gpr_wdata;
    end
  end

  function automatic logic [XLEN-1:0] gpr_read(input logic [GPR_AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = '0;
    if (addr != '0) begin
      val = gpr[addr];
`ifdef EXU_DP_WR_BYPASS_EN
      if (bus.gpr_wen && (bus.gpr_waddr == addr)) begin
        val = bus.gpr_wdata;
      end
`endif
    end
    return val;
  endfunction

  assign bus.gpr_rdata1 = gpr_read(bus.gpr_raddr1);
  assign bus.gpr_rdata2 = gpr_read(bus.gpr_raddr2);

  exu_alu #(
    .XLEN      (XLEN),
    .ALU_OPC_W (ALU_OPC_W)
  ) u_alu (
    .opcode (bus.alu_opcode),
    .src1   (bus.alu_src1),
    .src2   (bus.alu_src2),
    .dst    (bus.alu_dst)
  );

endmodule

// File: tb/tb_exu_dp_modport.sv
// tb/tb_exu_dp_modport.sv - directed bench for exu_dp_modport (honours EXU_DP_WR_BYPASS_EN)
module tb_exu_dp_modport;

  logic clk;
  logic rst_n;

  exu_dp_modport_if bus ();

  exu_dp_modport dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic [3:0]  opc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic gpr_write(input logic [4:0] addr, input logic [31:0] data);
    bus.gpr_waddr = addr;
    bus.gpr_wdata = data;
    bus.gpr_wen   = 1'b1;
    @(posedge clk);
    #1;
    bus.gpr_wen   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.gpr_raddr1 = 5'd31;
    bus.gpr_raddr2 = 5'd1;
    bus.gpr_waddr  = '0;
    bus.gpr_wdata  = '0;
    bus.gpr_wen    = 1'b0;
    bus.alu_opcode = '0;
    bus.alu_src1   = '0;
    bus.alu_src2   = '0;

    #1;
    check("reset_rd1_x31", bus.gpr_rdata1, 32'h0);
    check("reset_rd2_x1", bus.gpr_rdata2, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset clears previously written contents, asynchronously
    gpr_write(5'd5, 32'hDEADBEEF);
    bus.gpr_raddr1 = 5'd5;
    #1 check("x5_written", bus.gpr_rdata1, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1 check("x5_async_reset", bus.gpr_rdata1, 32'h0);
    bus.gpr_waddr = 5'd5;
    bus.gpr_wdata = 32'h11111111;
    bus.gpr_wen   = 1'b1;
    @(posedge clk);
    #1 check("write_blocked_in_reset", bus.gpr_rdata1, 32'h0);
    bus.gpr_wen = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("x5_after_release", bus.gpr_rdata1, 32'h0);

    // Basic write/read and x0
    gpr_write(5'd7, 32'h12345678);
    bus.gpr_raddr1 = 5'd7;
    bus.gpr_raddr2 = 5'd0;
    #1;
    check("x7_read", bus.gpr_rdata1, 32'h12345678);
    check("x0_read", bus.gpr_rdata2, 32'h0);
    gpr_write(5'd0, 32'hFFFFFFFF);
    #1 check("x0_after_write", bus.gpr_rdata2, 32'h0);
    check("x7_kept", bus.gpr_rdata1, 32'h12345678);

    // Same-cycle read and write of x3
    gpr_write(5'd3, 32'h1);
    bus.gpr_raddr1 = 5'd3;
    bus.gpr_raddr2 = 5'd0;
    bus.gpr_waddr  = 5'd3;
    bus.gpr_wdata  = 32'h2;
    bus.gpr_wen    = 1'b1;
    #1;
`ifdef EXU_DP_WR_BYPASS_EN
    check("x3_same_cycle", bus.gpr_rdata1, 32'h2);
`else
    check("x3_same_cycle", bus.gpr_rdata1, 32'h1);
`endif
    bus.gpr_waddr = 5'd0;
    #1 check("x0_wen_addr0_rd0", bus.gpr_rdata2, 32'h0);
    bus.gpr_waddr = 5'd3;
    @(posedge clk);
    #1 bus.gpr_wen = 1'b0;
    #1 check("x3_after_edge", bus.gpr_rdata1, 32'h2);

    // ALU vectors
    vecs.push_back('{"add_wrap",  4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    vecs.push_back('{"add_basic", 4'd0,  32'h00001234, 32'h00000111, 32'h00001345});
    vecs.push_back('{"sub_wrap",  4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF});
    vecs.push_back('{"less_s",    4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000001});
    vecs.push_back('{"less_s_n",  4'd2,  32'h00000001, 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"less_u",    4'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    vecs.push_back('{"less_u_y",  4'd3,  32'h00000001, 32'hFFFFFFFF, 32'h00000001});
    vecs.push_back('{"xor",       4'd4,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00});
    vecs.push_back('{"or",        4'd5,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0});
    vecs.push_back('{"and",       4'd6,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0});
    vecs.push_back('{"sl",        4'd7,  32'h80000000, 32'h00000021, 32'h00000000});
    vecs.push_back('{"sl_4",      4'd7,  32'h0000000F, 32'hFFFFFFE4, 32'h000000F0});
    vecs.push_back('{"srl",       4'd8,  32'h80000000, 32'h00000021, 32'h40000000});
    vecs.push_back('{"sra",       4'd9,  32'h80000000, 32'h00000021, 32'hC0000000});
    vecs.push_back('{"sra_pos",   4'd9,  32'h40000000, 32'h0000001E, 32'h00000001});
    vecs.push_back('{"illegal10", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"illegal12", 4'd12, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000000});
    vecs.push_back('{"illegal15", 4'd15, 32'h12345678, 32'h00000001, 32'h00000000});

    foreach (vecs[i]) begin
      bus.alu_opcode = vecs[i].opc;
      bus.alu_src1   = vecs[i].src1;
      bus.alu_src2   = vecs[i].src2;
      #1 check(vecs[i].name, bus.alu_dst, vecs[i].exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
